// File: rtl/vid_pixel_feeder.sv
// -----------------------------------------------------------------------------
// vid_pixel_feeder
// Pixel source for the HDMI output stage. RGB565 beats from the frame reader
// are buffered in a FIFO. The stream is re-aligned to each frame on the VS
// edge: the FIFO is flushed and beats are discarded until one marked start-of-
// frame arrives. One pixel is popped per DE cycle, with a one-cycle latency.
//
// Optional feature: define VFEED_PATTERN_EN to build in an 8-bar colour test
// pattern selected by pattern_en. When the macro is not defined, pattern_en is
// ignored and no bar logic is built.
//
// Ports
//   video_clk   pixel clock, only clock
//   rst_n       synchronous reset, active low
//   vs_i, de_i  VS and DE (pixel request) from the timing generator
//   s_data/s_sof/s_valid/s_ready  upstream pixel beat handshake
//   pattern_en  colour bar select (VFEED_PATTERN_EN builds only)
//   pix_data/pix_de  pixel pair to the TMDS path
//   fifo_level  current FIFO occupancy
//   underflow   sticky: DE seen while the FIFO was empty or flushing
//   frame_err   sticky: wrong pixel count per frame, or SOF inside a frame
// -----------------------------------------------------------------------------
module vid_pixel_feeder #(
    parameter int                DATA_W     = 16,
    parameter int                FIFO_DEPTH = 1024,
    parameter int                H_ACTIVE   = 1280,
    parameter int                V_ACTIVE   = 720,
    parameter logic              VS_POL     = 1'b1,
    parameter logic [DATA_W-1:0] FILL_COLOR = 16'h0000
) (
    input  logic                          video_clk,
    input  logic                          rst_n,
    input  logic                          vs_i,
    input  logic                          de_i,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_sof,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          pattern_en,
    output logic [DATA_W-1:0]             pix_data,
    output logic                          pix_de,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow,
    output logic                          frame_err
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          PTR_W     = AW + 1;
    localparam logic [20:0] FRAME_PIX = 21'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {
        ST_FLUSH    = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [PTR_W-1:0]   fifo_level_r;
    logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
    logic               vs_d_r, vs_edge_s;
    logic               empty_s, full_s, full_nxt_s;
    logic               wr_en_s, pop_s;
    logic               s_ready_r, s_ready_nxt_s;
    logic [DATA_W-1:0]  pix_fifo_s, pix_nxt_s, pix_data_r;
    logic               pix_de_r, underflow_r, frame_err_r, first_frame_r;
    logic [20:0]        px_cnt_r;

    assign vs_edge_s  = (vs_d_r == ~VS_POL) && (vs_i == VS_POL);
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign full_nxt_s = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                        (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);

    assign s_ready    = s_ready_r;
    assign pix_data   = pix_data_r;
    assign pix_de     = pix_de_r;
    assign fifo_level = fifo_level_r;
    assign underflow  = underflow_r;
    assign frame_err  = frame_err_r;

    // Next state, write/pop decisions, next pointers and next s_ready.
    // s_ready is computed from the next state/occupancy so the registered
    // copy always describes the cycle it is presented in.
    always_comb begin
        state_nxt_s   = state_r;
        wr_en_s       = 1'b0;
        s_ready_nxt_s = 1'b0;
        pop_s         = de_i && !empty_s && (state_r != ST_FLUSH);
        case (state_r)
            ST_FLUSH: begin
                state_nxt_s = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                // Non-SOF beats are accepted and dropped to resync the stream.
                if (s_valid && s_ready_r && s_sof && !full_s) begin
                    wr_en_s     = 1'b1;
                    state_nxt_s = ST_STREAM;
                end else begin
                    wr_en_s     = 1'b0;
                end
            end
            ST_STREAM: begin
                if (s_valid && s_ready_r && !full_s) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_FLUSH;
            end
        endcase
        // A frame boundary overrides everything and drops this cycle's write.
        if (vs_edge_s) begin
            state_nxt_s = ST_FLUSH;
            wr_en_s     = 1'b0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
        if (state_r == ST_FLUSH) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(wr_en_s);
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
        end
        case (state_nxt_s)
            ST_WAIT_SOF: s_ready_nxt_s = 1'b1;
            ST_STREAM:   s_ready_nxt_s = !full_nxt_s;
            default:     s_ready_nxt_s = 1'b0;
        endcase
    end

    // FSM state, FIFO pointers, occupancy, s_ready and VS history.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT_SOF;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_level_r <= {PTR_W{1'b0}};
            s_ready_r    <= 1'b0;
            vs_d_r       <= VS_POL;
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            fifo_level_r <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            s_ready_r    <= s_ready_nxt_s;
            vs_d_r       <= vs_i;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge video_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= s_data;
        end
    end

    // Pixel taken from the FIFO, fill colour on starvation, zero in blanking.
    always_comb begin
        if (pop_s) begin
            pix_fifo_s = mem_r[rd_ptr_r[AW-1:0]];
        end else if (de_i) begin
            pix_fifo_s = FILL_COLOR;
        end else begin
            pix_fifo_s = {DATA_W{1'b0}};
        end
    end

`ifdef VFEED_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int XW    = $clog2(H_ACTIVE) + 1;

    logic [XW-1:0] x_cnt_r;
    logic [2:0]    bar_idx_s;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    // Over-long lines stay on the last bar instead of wrapping.
    assign bar_idx_s = (x_cnt_r >= XW'(8 * BAR_W)) ? 3'd7 : 3'(x_cnt_r / XW'(BAR_W));
    assign pix_nxt_s = (pattern_en && de_i) ? DATA_W'(bar_color(bar_idx_s)) : pix_fifo_s;

    // Horizontal position within the current DE run.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            x_cnt_r <= {XW{1'b0}};
        end else if (de_i) begin
            x_cnt_r <= x_cnt_r + {{(XW-1){1'b0}}, 1'b1};
        end else begin
            x_cnt_r <= {XW{1'b0}};
        end
    end
`else
    logic unused_pattern_en_s;
    assign unused_pattern_en_s = pattern_en;
    assign pix_nxt_s           = pix_fifo_s;
`endif

    // Registered output pixel pair and sticky underflow.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            pix_data_r  <= {DATA_W{1'b0}};
            pix_de_r    <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            pix_data_r <= pix_nxt_s;
            pix_de_r   <= de_i;
            if (de_i && !pop_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Frame pixel count check and mid-frame SOF detection. The first VS after
    // reset only starts counting, since the frame before it was partial.
    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            px_cnt_r      <= 21'd0;
            first_frame_r <= 1'b1;
            frame_err_r   <= 1'b0;
        end else begin
            if (vs_edge_s) begin
                if (!first_frame_r && (px_cnt_r != FRAME_PIX)) begin
                    frame_err_r <= 1'b1;
                end
                px_cnt_r      <= 21'd0;
                first_frame_r <= 1'b0;
            end else if (de_i) begin
                px_cnt_r <= px_cnt_r + 21'd1;
            end
            if ((state_r == ST_STREAM) && s_valid && s_ready_r && s_sof) begin
                frame_err_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vid_pixel_feeder.sv
// -----------------------------------------------------------------------------
// tb_vid_pixel_feeder
// Directed scenarios followed by randomized traffic for vid_pixel_feeder
// (8x2 frame, 8-entry FIFO). A queue-based reference model predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_vid_pixel_feeder;
    localparam int   H    = 8;
    localparam int   V    = 2;
    localparam int   D    = 8;
    localparam logic POL  = 1'b1;
    localparam logic [15:0] FILL = 16'h0000;

    logic        video_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_i = 1'b0;
    logic        de_i = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        pattern_en = 1'b0;
    logic [15:0] pix_data;
    logic        pix_de;
    logic [3:0]  fifo_level;
    logic        underflow;
    logic        frame_err;

    vid_pixel_feeder #(
        .DATA_W(16), .FIFO_DEPTH(D), .H_ACTIVE(H), .V_ACTIVE(V),
        .VS_POL(POL), .FILL_COLOR(FILL)
    ) dut (
        .video_clk(video_clk), .rst_n(rst_n), .vs_i(vs_i), .de_i(de_i),
        .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
        .pattern_en(pattern_en), .pix_data(pix_data), .pix_de(pix_de),
        .fifo_level(fifo_level), .underflow(underflow), .frame_err(frame_err)
    );

    always #5 video_clk = ~video_clk;

    typedef struct { logic [15:0] d; logic sof; } beat_t;
    typedef enum { M_FLUSH, M_WAIT, M_STREAM } mode_t;

    beat_t       src[$];
    logic [15:0] q[$];
    mode_t       mode_m;
    logic        ready_m, uf_m, ferr_m, first_m, vs_prev_m;
    int          px_m, x_m;
    int          valid_pct = 100;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode_m = M_WAIT; ready_m = 1'b0; uf_m = 1'b0; ferr_m = 1'b0;
        first_m = 1'b1; vs_prev_m = POL; px_m = 0; x_m = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; de_i = 1'b1; s_valid = 1'b1; s_sof = 1'b1; vs_i = 1'b0;
        repeat (2) @(posedge video_clk);
        #1;
        model_reset();
        check("rst_pix_data", 32'(pix_data), 32'h0);
        check("rst_pix_de", 32'(pix_de), 32'h0);
        check("rst_fifo_level", 32'(fifo_level), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_s_ready", 32'(s_ready), 32'h0);
        rst_n = 1'b1; de_i = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic tick(input logic de, input logic vs);
        logic        acc, vse, wr;
        logic [15:0] ep;
        de_i = de; vs_i = vs;
        if (src.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
            s_valid = 1'b1; s_data = src[0].d; s_sof = src[0].sof;
        end else begin
            s_valid = 1'b0; s_data = 16'($urandom); s_sof = 1'($urandom);
        end
        vse = (vs_prev_m == ~POL) && (vs == POL);
        acc = s_valid && ready_m;
        if (de) begin
            if (q.size() > 0 && mode_m != M_FLUSH) ep = q.pop_front();
            else begin ep = FILL; uf_m = 1'b1; end
`ifdef VFEED_PATTERN_EN
            if (pattern_en) ep = bars[(x_m / (H / 8)) > 7 ? 7 : (x_m / (H / 8))];
`endif
            x_m++;
        end else begin
            ep = 16'h0000; x_m = 0;
        end
        wr = acc && !vse && (mode_m == M_STREAM || (mode_m == M_WAIT && s_sof));
        if (mode_m == M_STREAM && acc && s_sof) ferr_m = 1'b1;
        if (wr) q.push_back(s_data);
        if (vse) begin
            if (!first_m && px_m != H * V) ferr_m = 1'b1;
            px_m = 0; first_m = 1'b0;
        end else if (de) px_m++;
        if (mode_m == M_FLUSH) q.delete();
        if (vse) mode_m = M_FLUSH;
        else if (mode_m == M_FLUSH) mode_m = M_WAIT;
        else if (mode_m == M_WAIT && wr) mode_m = M_STREAM;
        ready_m = (mode_m == M_WAIT) ? 1'b1 : (mode_m == M_STREAM) ? (q.size() < D) : 1'b0;
        vs_prev_m = vs;
        @(posedge video_clk);
        #1;
        check("pix_data", 32'(pix_data), 32'(ep));
        check("pix_de", 32'(pix_de), 32'(de));
        check("fifo_level", 32'(fifo_level), 32'(q.size()));
        check("underflow", 32'(underflow), 32'(uf_m));
        check("frame_err", 32'(frame_err), 32'(ferr_m));
        check("s_ready", 32'(s_ready), 32'(ready_m));
        if (acc) void'(src.pop_front());
    endtask

    task automatic push_beat(input logic [15:0] d, input logic sof);
        beat_t b;
        b.d = d; b.sof = sof;
        src.push_back(b);
    endtask

    // One roughly well-formed frame with occasional length errors.
    task automatic rand_frame();
        int len, n;
        len = ($urandom_range(0, 9) == 0) ? 15 + 2 * $urandom_range(0, 1) : H * V;
        for (int i = 0; i < len; i++) push_beat(16'($urandom), i == 0);
        for (int l = 0; l < V; l++) begin
            repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0);
            n = ($urandom_range(0, 9) == 0) ? H - 1 + 2 * $urandom_range(0, 1) : H;
            repeat (n) tick(1'b1, 1'b0);
        end
        repeat (2) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        if (src.size() > 48) src.delete();
    endtask

    initial begin
        do_reset();

        // Fill: 16 beats offered, only D accepted while no DE runs.
        for (int i = 1; i <= 16; i++) push_beat(16'(i), i == 1);
        repeat (10) tick(1'b0, 1'b0);
        check("fill_level", 32'(fifo_level), 32'd8);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        for (int i = 17; i <= 20; i++) push_beat(16'(i), 1'b0);
        // Two lines of DE: pixels 1..16 in order.
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < H; p++) begin
                tick(1'b1, 1'b0);
                check("line_pixel", 32'(pix_data), 32'(l * H + p + 1));
            end
            repeat (4) tick(1'b0, 1'b0);
        end
        check("no_underflow", 32'(underflow), 32'd0);

        // Drain the remaining 4 then starve the read side.
        repeat (6) tick(1'b1, 1'b0);
        check("starve_pix", 32'(pix_data), 32'h0000);
        check("starve_de", 32'(pix_de), 32'd1);
        check("underflow_set", 32'(underflow), 32'd1);
        repeat (3) tick(1'b0, 1'b0);
        check("underflow_sticky", 32'(underflow), 32'd1);

        // VS with 5 beats queued flushes the FIFO.
        for (int i = 0; i < 5; i++) push_beat(16'h0100 + 16'(i), 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        check("pre_vs_level", 32'(fifo_level), 32'd5);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("flush_level", 32'(fifo_level), 32'd0);
        check("wait_s_ready", 32'(s_ready), 32'd1);
        tick(1'b0, 1'b0);

        // Resync: non-SOF beats dropped, SOF beat kept.
        for (int i = 0; i < 3; i++) push_beat(16'h0200 + 16'(i), 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        check("discard_level", 32'(fifo_level), 32'd0);
        push_beat(16'hABCD, 1'b1);
        repeat (2) tick(1'b0, 1'b0);
        check("sof_level", 32'(fifo_level), 32'd1);
        tick(1'b1, 1'b0);
        check("sof_pixel", 32'(pix_data), 32'hABCD);

        // Exact-length frame (16 DE) then a short one (15 DE).
        repeat (15) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("good_frame", 32'(frame_err), 32'd0);
        tick(1'b0, 1'b0);
        repeat (15) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("short_frame", 32'(frame_err), 32'd1);
        tick(1'b0, 1'b0);

`ifdef VFEED_PATTERN_EN
        pattern_en = 1'b1;
        tick(1'b0, 1'b0);
        for (int p = 0; p < H; p++) begin
            tick(1'b1, 1'b0);
            check("bar", 32'(pix_data), 32'(bars[p]));
        end
        tick(1'b0, 1'b0);
        pattern_en = 1'b0;
`endif

        // Randomized framed traffic after a fresh reset.
        src.delete();
        do_reset();
        valid_pct = 75;
        for (int f = 0; f < 40; f++) begin
`ifdef VFEED_PATTERN_EN
            pattern_en = 1'($urandom_range(0, 3) == 0);
`endif
            rand_frame();
        end

        // Unstructured random traffic.
        src.delete();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (src.size() < 4) push_beat(16'($urandom), $urandom_range(0, 7) == 0);
            valid_pct = $urandom_range(30, 100);
            tick(1'($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 24) == 0) ? ~vs_i : vs_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
